// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl_pkg
// Purpose  : Shared state encoding, source count, cause-code prefix and a
//            lowest-set-bit priority helper for the interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

    localparam int       c_NUM_SRC     = 8;
    localparam int       c_IDX_W       = 3;
    localparam bit       c_CODE_PREFIX = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } state_t;

    // Index of the lowest set bit; bit 0 has the highest priority.
    function automatic logic [c_IDX_W-1:0] lowest_idx(input logic [c_NUM_SRC-1:0] vec);
        logic [c_IDX_W-1:0] res;
        res = '0;
        for (int i = c_NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = c_IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_ctrl_irq_sync.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync
// Purpose  : Two-flop synchronizer for one asynchronous interrupt line plus a
//            one-cycle rising-edge pulse on the synchronized value.
// Revision : 1.0 - initial release
// ============================================================================
module irq_sync (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic PULSE
);

    logic r_sync0;
    logic r_sync1;
    logic r_prev;

    // Synchronizer chain and delayed copy used for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync0 <= D;
            r_sync1 <= r_sync0;
            r_prev  <= r_sync1;
        end
    end

    assign PULSE = r_sync1 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl
// Purpose  : Edge-triggered, maskable, fixed-priority interrupt controller
//            offering one non-nested interrupt at a time to the trap unit.
// Revision : 1.0 - initial release
// ============================================================================
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = c_NUM_SRC
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic               MEM_WAIT,
    input  logic               CFG_WE,
    input  logic [NUM_SRC-1:0] CFG_MASK,
    input  logic               TRAP_TAKEN,
    input  logic               INT_DONE,
    output logic               INT_EN,
    output logic [3:0]         INT_CODE,
    output logic [NUM_SRC-1:0] MASK_OUT,
    output logic [NUM_SRC-1:0] PENDING_OUT,
    output logic               BUSY
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [NUM_SRC-1:0]   r_mask;
    logic [NUM_SRC-1:0]   r_pending;
    logic [NUM_SRC-1:0]   w_edge;
    logic [NUM_SRC-1:0]   w_clr;
    logic [NUM_SRC-1:0]   w_eligible;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
            irq_sync u_irq_sync (
                .CLK   (CLK),
                .RST_N (RST_N),
                .D     (IRQ[i]),
                .PULSE (w_edge[i])
            );
        end
    endgenerate

    assign w_eligible = r_pending & r_mask;

    // Mask register; writes are accepted even while the pipeline is stalled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mask <= '0;
        end else if (CFG_WE) begin
            r_mask <= CFG_MASK;
        end
    end

    // Pending bits: a new edge wins over a same-cycle clear of that source.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
        end
    end

    // State and captured source index.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic; a stall freezes everything including the pending clear.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_clr       = '0;
        if (!MEM_WAIT) begin
            case (r_state)
                IDLE: begin
                    if (|w_eligible) begin
                        w_idx_nxt   = lowest_idx(w_eligible);
                        w_state_nxt = REQ;
                    end
                end
                REQ: begin
                    if (TRAP_TAKEN) begin
                        w_clr       = NUM_SRC'(1) << r_idx;
                        w_state_nxt = SERVE;
                    end else if (!r_mask[r_idx]) begin
                        w_state_nxt = IDLE;
                    end
                end
                SERVE: begin
                    if (INT_DONE) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign INT_EN      = (r_state == REQ);
    assign BUSY        = (r_state == SERVE);
    assign INT_CODE    = (r_state == IDLE) ? 4'h0 : {c_CODE_PREFIX, r_idx};
    assign MASK_OUT    = r_mask;
    assign PENDING_OUT = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_ctrl
// Purpose  : Directed self-checking bench for the interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

    logic       CLK;
    logic       RST_N;
    logic [7:0] IRQ;
    logic       MEM_WAIT;
    logic       CFG_WE;
    logic [7:0] CFG_MASK;
    logic       TRAP_TAKEN;
    logic       INT_DONE;
    logic       INT_EN;
    logic [3:0] INT_CODE;
    logic [7:0] MASK_OUT;
    logic [7:0] PENDING_OUT;
    logic       BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    int_ctrl #(.NUM_SRC(8)) u_dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IRQ         (IRQ),
        .MEM_WAIT    (MEM_WAIT),
        .CFG_WE      (CFG_WE),
        .CFG_MASK    (CFG_MASK),
        .TRAP_TAKEN  (TRAP_TAKEN),
        .INT_DONE    (INT_DONE),
        .INT_EN      (INT_EN),
        .INT_CODE    (INT_CODE),
        .MASK_OUT    (MASK_OUT),
        .PENDING_OUT (PENDING_OUT),
        .BUSY        (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples sit 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_mask(input logic [7:0] m);
        CFG_WE   = 1'b1;
        CFG_MASK = m;
        tick();
        CFG_WE   = 1'b0;
    endtask

    // One-cycle IRQ pulse; on return the resulting pending bits are visible.
    task automatic pulse_irq(input logic [7:0] m);
        IRQ = m;
        tick();
        IRQ = 8'h00;
        tick();
        tick();
    endtask

    task automatic trap();
        TRAP_TAKEN = 1'b1;
        tick();
        TRAP_TAKEN = 1'b0;
    endtask

    task automatic done();
        INT_DONE = 1'b1;
        tick();
        INT_DONE = 1'b0;
    endtask

    initial begin
        RST_N      = 1'b0;
        IRQ        = 8'h00;
        MEM_WAIT   = 1'b0;
        CFG_WE     = 1'b0;
        CFG_MASK   = 8'h00;
        TRAP_TAKEN = 1'b0;
        INT_DONE   = 1'b0;
        tick();
        tick();
        check("rst_int_en",  32'(INT_EN), 32'h0);
        check("rst_code",    32'(INT_CODE), 32'h0);
        check("rst_busy",    32'(BUSY), 32'h0);
        check("rst_mask",    32'(MASK_OUT), 32'h00);
        check("rst_pending", 32'(PENDING_OUT), 32'h00);
        RST_N = 1'b1;
        tick();

        // Single source 3
        write_mask(8'hFF);
        check("mask_ff", 32'(MASK_OUT), 32'hFF);
        pulse_irq(8'h08);
        check("s3_pending", 32'(PENDING_OUT), 32'h08);
        check("s3_en_before", 32'(INT_EN), 32'h0);
        tick();
        check("s3_en",   32'(INT_EN), 32'h1);
        check("s3_code", 32'(INT_CODE), 32'hB);
        trap();
        check("s3_busy",    32'(BUSY), 32'h1);
        check("s3_en_off",  32'(INT_EN), 32'h0);
        check("s3_cleared", 32'(PENDING_OUT), 32'h00);
        done();
        check("s3_idle_busy", 32'(BUSY), 32'h0);
        check("s3_idle_code", 32'(INT_CODE), 32'h0);

        // Simultaneous sources 5 and 1: lowest index first
        pulse_irq(8'h22);
        check("pr_pending", 32'(PENDING_OUT), 32'h22);
        tick();
        check("pr_code_first", 32'(INT_CODE), 32'h9);
        trap();
        check("pr_pending_left", 32'(PENDING_OUT), 32'h20);
        done();
        tick();
        check("pr_en_second",   32'(INT_EN), 32'h1);
        check("pr_code_second", 32'(INT_CODE), 32'hD);
        trap();
        done();
        check("pr_all_clear", 32'(PENDING_OUT), 32'h00);

        // Masked source latches pending, unmask releases it
        write_mask(8'h00);
        pulse_irq(8'h04);
        check("mk_pending", 32'(PENDING_OUT), 32'h04);
        tick();
        check("mk_en_held", 32'(INT_EN), 32'h0);
        write_mask(8'h04);
        tick();
        check("mk_en",   32'(INT_EN), 32'h1);
        check("mk_code", 32'(INT_CODE), 32'hA);
        trap();
        done();

        // Withdraw when mask drops while offering source 6
        write_mask(8'hFF);
        pulse_irq(8'h40);
        tick();
        check("wd_code", 32'(INT_CODE), 32'hE);
        write_mask(8'h00);
        check("wd_en_same", 32'(INT_EN), 32'h1);
        tick();
        check("wd_en_off",  32'(INT_EN), 32'h0);
        check("wd_pending", 32'(PENDING_OUT), 32'h40);
        write_mask(8'hFF);
        tick();
        check("wd_reoffer", 32'(INT_CODE), 32'hE);
        trap();
        done();

        // Stall holds the offer and defers TRAP_TAKEN
        pulse_irq(8'h08);
        tick();
        MEM_WAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_en",   32'(INT_EN), 32'h1);
            check("st_code", 32'(INT_CODE), 32'hB);
        end
        TRAP_TAKEN = 1'b1;
        tick();
        check("st_trap_held", 32'(BUSY), 32'h0);
        check("st_pend_held", 32'(PENDING_OUT), 32'h08);
        MEM_WAIT = 1'b0;
        tick();
        TRAP_TAKEN = 1'b0;
        check("st_serve", 32'(BUSY), 32'h1);

        // No nesting in SERVE, then reset abandons everything
        pulse_irq(8'h02);
        tick();
        check("nn_busy",    32'(BUSY), 32'h1);
        check("nn_en",      32'(INT_EN), 32'h0);
        check("nn_pending", 32'(PENDING_OUT), 32'h02);
        #2;
        RST_N = 1'b0;
        #1;
        check("ar_busy",    32'(BUSY), 32'h0);
        check("ar_en",      32'(INT_EN), 32'h0);
        check("ar_code",    32'(INT_CODE), 32'h0);
        check("ar_mask",    32'(MASK_OUT), 32'h00);
        check("ar_pending", 32'(PENDING_OUT), 32'h00);
        tick();
        RST_N = 1'b1;
        tick();

        // Edge on source 0 in the same cycle it is taken
        write_mask(8'hFF);
        pulse_irq(8'h01);
        tick();
        check("sw_code", 32'(INT_CODE), 32'h8);
        IRQ = 8'h01;
        tick();
        IRQ = 8'h00;
        tick();
        trap();
        check("sw_busy",    32'(BUSY), 32'h1);
        check("sw_pending", 32'(PENDING_OUT), 32'h01);
        done();
        tick();
        check("sw_en_again",   32'(INT_EN), 32'h1);
        check("sw_code_again", 32'(INT_CODE), 32'h8);
        trap();
        check("sw_cleared", 32'(PENDING_OUT), 32'h00);

        // Strobes outside their states are ignored
        done();
        trap();
        check("ig_busy", 32'(BUSY), 32'h0);
        done();
        check("ig_en", 32'(INT_EN), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
